// File: rtl/t03_regfile_pkg.sv
// rtl/t03_regfile_pkg.sv - shared constants, index type and read-only defaults for the t03 register file
package t03_regfile_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = reg_idx_t'(0);
    localparam reg_idx_t REG_RO0  = reg_idx_t'(29);
    localparam reg_idx_t REG_RO1  = reg_idx_t'(30);
    localparam reg_idx_t REG_RO2  = reg_idx_t'(31);

    localparam logic [NREGS-1:0] RO_MASK_DEFAULT = 32'hE000_0001;

    // Packed MSB-first: reg31, reg30, reg29, then zeros down to reg0.
    localparam logic [NREGS*XLEN-1:0] RO_INIT_DEFAULT = {
        32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFC, {((NREGS-3)*XLEN){1'b0}}
    };

endpackage

// File: rtl/t03_scoreboard.sv
// rtl/t03_scoreboard.sv - busy-bit scoreboard: issue sets, write-back clears, flush wipes
module t03_scoreboard
    import t03_regfile_pkg::*;
#(
    parameter int               NREGS   = t03_regfile_pkg::NREGS,
    parameter int               AW      = $clog2(NREGS),
    parameter logic [NREGS-1:0] RO_MASK = RO_MASK_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic             iss_valid_i,
    input  logic [AW-1:0]    iss_rd_i,
    input  logic             wb_valid_i,
    input  logic [AW-1:0]    wb_rd_i,
    output logic [NREGS-1:0] busy_o,
    output logic             iss_ready_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {{(32-AW){1'b0}}, a} < 32'(NREGS);
    endfunction

    function automatic logic is_ro(input logic [AW-1:0] a);
        return in_range(a) ? RO_MASK[a] : 1'b0;
    endfunction

    // Read-only and out-of-range destinations never stall the issuer.
    assign iss_ready_o = (!in_range(iss_rd_i) || is_ro(iss_rd_i)) ? 1'b1 : !busy_q[iss_rd_i];
    assign busy_o      = busy_q;

    always_comb begin
        busy_d = busy_q;
        if (en_i) begin
            if (wb_valid_i && in_range(wb_rd_i)) begin
                busy_d[wb_rd_i] = 1'b0;
            end
            // Set after clear so a same-register issue wins over write-back.
            if (iss_valid_i && iss_ready_o && in_range(iss_rd_i) && !is_ro(iss_rd_i)) begin
                busy_d[iss_rd_i] = 1'b1;
            end
        end
        if (flush_i) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/t03_regfile_scoreboard.sv
// rtl/t03_regfile_scoreboard.sv - integer register file with busy scoreboard; optional T03_REGFILE_BYPASS_EN forwarding
module t03_regfile_scoreboard
    import t03_regfile_pkg::*;
#(
    parameter int                    XLEN    = t03_regfile_pkg::XLEN,
    parameter int                    NREGS   = t03_regfile_pkg::NREGS,
    parameter int                    AW      = $clog2(NREGS),
    parameter int                    NRD     = 2,
    parameter logic [NREGS-1:0]      RO_MASK = RO_MASK_DEFAULT,
    parameter logic [NREGS*XLEN-1:0] RO_INIT = RO_INIT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic                flush_i,
    input  logic [NRD*AW-1:0]   rs_addr_i,
    output logic [NRD*XLEN-1:0] rs_data_o,
    output logic [NRD-1:0]      rs_busy_o,
    input  logic                iss_valid_i,
    input  logic [AW-1:0]       iss_rd_i,
    output logic                iss_ready_o,
    input  logic                wb_valid_i,
    input  logic [AW-1:0]       wb_rd_i,
    input  logic [XLEN-1:0]     wb_data_i
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy;
    logic             wr_en;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {{(32-AW){1'b0}}, a} < 32'(NREGS);
    endfunction

    function automatic logic is_ro(input logic [AW-1:0] a);
        return in_range(a) ? RO_MASK[a] : 1'b0;
    endfunction

    t03_scoreboard #(
        .NREGS   (NREGS),
        .AW      (AW),
        .RO_MASK (RO_MASK)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .flush_i     (flush_i),
        .iss_valid_i (iss_valid_i),
        .iss_rd_i    (iss_rd_i),
        .wb_valid_i  (wb_valid_i),
        .wb_rd_i     (wb_rd_i),
        .busy_o      (busy),
        .iss_ready_o (iss_ready_o)
    );

    assign wr_en = en_i && wb_valid_i && in_range(wb_rd_i) && !is_ro(wb_rd_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= RO_INIT[i*XLEN +: XLEN];
            end
        end else if (wr_en) begin
            regs_q[wb_rd_i] <= wb_data_i;
        end
    end

`ifdef T03_REGFILE_BYPASS_EN
    logic iss_set;
    assign iss_set = en_i && iss_valid_i && iss_ready_o && in_range(iss_rd_i) && !is_ro(iss_rd_i);
`endif

    always_comb begin
        rs_data_o = '0;
        rs_busy_o = '0;
        for (int p = 0; p < NRD; p++) begin
            if (in_range(rs_addr_i[p*AW +: AW])) begin
                rs_data_o[p*XLEN +: XLEN] = regs_q[rs_addr_i[p*AW +: AW]];
                rs_busy_o[p] = busy[rs_addr_i[p*AW +: AW]] && !is_ro(rs_addr_i[p*AW +: AW]);
            end
`ifdef T03_REGFILE_BYPASS_EN
            // Forwarded data is ready now unless the same register is re-issued this cycle.
            if (wr_en && rs_addr_i[p*AW +: AW] == wb_rd_i) begin
                rs_data_o[p*XLEN +: XLEN] = wb_data_i;
                rs_busy_o[p] = iss_set && (iss_rd_i == wb_rd_i);
            end
`endif
        end
    end

endmodule

// File: tb/tb_t03_regfile_scoreboard.sv
// tb/tb_t03_regfile_scoreboard.sv - self-checking bench with behavioural register/busy model
module tb_t03_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en, flush, iss_valid, wb_valid, iss_ready;
    logic [4:0]  iss_rd, wb_rd;
    logic [31:0] wb_data;
    logic [9:0]  rs_addr;
    logic [63:0] rs_data;
    logic [1:0]  rs_busy;

    logic [31:0] mregs [32];
    bit          mbusy [32];
    logic [31:0] ro_mask = 32'hE000_0001;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    t03_regfile_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .flush_i     (flush),
        .rs_addr_i   (rs_addr),
        .rs_data_o   (rs_data),
        .rs_busy_o   (rs_busy),
        .iss_valid_i (iss_valid),
        .iss_rd_i    (iss_rd),
        .iss_ready_o (iss_ready),
        .wb_valid_i  (wb_valid),
        .wb_rd_i     (wb_rd),
        .wb_data_i   (wb_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        case (i)
            31:      return 32'hFFFF_FFFF;
            30:      return 32'hFFFF_FFFD;
            29:      return 32'hFFFF_FFFC;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = init_val(i);
            mbusy[i] = 1'b0;
        end
    endtask

    function automatic bit exp_ready();
        return !mbusy[iss_rd] || ro_mask[iss_rd];
    endfunction

    function automatic bit issue_fires();
        return en && iss_valid && exp_ready() && !ro_mask[iss_rd];
    endfunction

    task automatic compare();
        logic [4:0]  a;
        logic [31:0] ed;
        bit          eb;
        for (int p = 0; p < 2; p++) begin
            a  = rs_addr[p*5 +: 5];
            ed = mregs[a];
            eb = mbusy[a] && !ro_mask[a];
`ifdef T03_REGFILE_BYPASS_EN
            if (en && wb_valid && !ro_mask[wb_rd] && a == wb_rd) begin
                ed = wb_data;
                eb = issue_fires() && iss_rd == a;
            end
`endif
            chk("rs_data", rs_data[p*32 +: 32], ed);
            chk("rs_busy", {31'b0, rs_busy[p]}, {31'b0, eb});
        end
        chk("iss_ready", {31'b0, iss_ready}, {31'b0, exp_ready()});
    endtask

    task automatic model_step();
        bit fire;
        fire = issue_fires();
        if (en && wb_valid && !ro_mask[wb_rd]) mregs[wb_rd] = wb_data;
        if (en && wb_valid) mbusy[wb_rd] = 1'b0;
        if (fire) mbusy[iss_rd] = 1'b1;
        if (flush) for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
    endtask

    task automatic cyc(input logic e, input logic f, input logic iv, input logic [4:0] ir,
                       input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] a0, input logic [4:0] a1);
        en = e; flush = f; iss_valid = iv; iss_rd = ir;
        wb_valid = wv; wb_rd = wr; wb_data = wd;
        rs_addr = {a1, a0};
        #1;
        compare();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    function automatic logic [4:0] pick();
        case ($urandom_range(0, 9))
            0: return 5'd0;
            1: return 5'd3;
            2: return 5'd5;
            3: return 5'd7;
            4: return 5'd9;
            5: return 5'd29;
            6: return 5'd30;
            7: return 5'd31;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic reset_checks();
        cyc(0, 0, 0, 5'd7, 0, 0, 0, 5'd29, 5'd30);
        chk("rst_x29", rs_data[31:0], 32'hFFFF_FFFC);
        chk("rst_x30", rs_data[63:32], 32'hFFFF_FFFD);
        chk("rst_busy", {30'b0, rs_busy}, 32'h0);
        chk("rst_ready", {31'b0, iss_ready}, 32'h1);
        cyc(0, 0, 0, 5'd7, 0, 0, 0, 5'd31, 5'd5);
        chk("rst_x31", rs_data[31:0], 32'hFFFF_FFFF);
        chk("rst_x5", rs_data[63:32], 32'h0);
    endtask

    initial begin
        en = 0; flush = 0; iss_valid = 0; iss_rd = 0;
        wb_valid = 0; wb_rd = 0; wb_data = 0; rs_addr = 0;
        model_reset();
        @(negedge clk);
        reset_checks();
        tick();
        rst = 1'b0;

        // write with and without enable
        cyc(1, 0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5); tick();
        cyc(1, 0, 0, 0, 0, 0, 0, 5'd5, 5'd0);
        chk("wb_x5", rs_data[31:0], 32'hDEAD_BEEF); tick();
        cyc(0, 0, 0, 0, 1, 5'd5, 32'h1111_1111, 5'd5, 5'd5); tick();
        cyc(1, 0, 0, 0, 0, 0, 0, 5'd5, 5'd0);
        chk("wb_x5_en0", rs_data[31:0], 32'hDEAD_BEEF); tick();

        // read-only registers
        cyc(1, 0, 0, 0, 1, 5'd0, 32'h1234, 5'd0, 5'd30); tick();
        cyc(1, 0, 0, 0, 1, 5'd30, 32'h1234, 5'd0, 5'd30); tick();
        cyc(1, 0, 1, 5'd0, 0, 0, 0, 5'd0, 5'd30);
        chk("ro_x0", rs_data[31:0], 32'h0);
        chk("ro_x30", rs_data[63:32], 32'hFFFF_FFFD); tick();
        cyc(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd30);
        chk("ro_x0_busy", {31'b0, rs_busy[0]}, 32'h0); tick();

        // issue / write-back / same-cycle set-wins
        cyc(1, 0, 1, 5'd7, 0, 0, 0, 5'd7, 5'd7); tick();
        cyc(1, 0, 0, 5'd7, 0, 0, 0, 5'd7, 5'd0);
        chk("x7_busy", {31'b0, rs_busy[0]}, 32'h1);
        chk("x7_ready", {31'b0, iss_ready}, 32'h0); tick();
        cyc(1, 0, 0, 5'd7, 1, 5'd7, 32'h55, 5'd0, 5'd0); tick();
        cyc(1, 0, 0, 5'd7, 0, 0, 0, 5'd7, 5'd0);
        chk("x7_clear", {31'b0, rs_busy[0]}, 32'h0); tick();
        cyc(1, 0, 1, 5'd7, 1, 5'd7, 32'h66, 5'd0, 5'd0); tick();
        cyc(1, 0, 0, 5'd7, 0, 0, 0, 5'd7, 5'd0);
        chk("x7_setwins", {31'b0, rs_busy[0]}, 32'h1); tick();
        cyc(1, 0, 0, 0, 1, 5'd7, 32'h77, 5'd0, 5'd0); tick();

        // flush beats same-cycle issue
        cyc(1, 0, 1, 5'd3, 0, 0, 0, 5'd3, 5'd9); tick();
        cyc(1, 0, 1, 5'd9, 0, 0, 0, 5'd3, 5'd9); tick();
        cyc(1, 1, 1, 5'd4, 0, 0, 0, 5'd3, 5'd9);
        chk("pre_flush", {30'b0, rs_busy}, 32'h3); tick();
        cyc(1, 0, 0, 0, 0, 0, 0, 5'd3, 5'd9);
        chk("flush_3_9", {30'b0, rs_busy}, 32'h0); tick();
        cyc(1, 0, 0, 0, 0, 0, 0, 5'd4, 5'd0);
        chk("flush_4", {31'b0, rs_busy[0]}, 32'h0); tick();

        // same-cycle write-back visibility
        cyc(1, 0, 1, 5'd9, 0, 0, 0, 5'd0, 5'd0); tick();
        cyc(1, 0, 0, 0, 1, 5'd9, 32'hCAFE_F00D, 5'd9, 5'd9);
`ifdef T03_REGFILE_BYPASS_EN
        chk("byp_data", rs_data[31:0], 32'hCAFE_F00D);
        chk("byp_busy", {31'b0, rs_busy[0]}, 32'h0);
`else
        chk("nobyp_data", rs_data[31:0], 32'h0);
        chk("nobyp_busy", {31'b0, rs_busy[0]}, 32'h1);
`endif
        tick();
        cyc(1, 0, 0, 0, 0, 0, 0, 5'd9, 5'd0);
        chk("x9_after", rs_data[31:0], 32'hCAFE_F00D); tick();

        // randomized traffic with a mid-run reset
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                rst = 1'b1;
                model_reset();
                reset_checks();
                tick();
                rst = 1'b0;
            end
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                1'($urandom_range(0, 1)), pick(), 1'($urandom_range(0, 1)), pick(),
                $urandom(), pick(), pick());
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
